// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, register-file constants and operand-resolve helper for the operand fetch stage.
// The register file uses the same constants, so the x0 rule and address widths stay consistent.
package operand_fetch_stage_pkg;

   localparam int XLEN     = 32;
   localparam int AW       = 5;
   localparam int CTRL_W   = 16;
   localparam int NUM_REGS = 32;
   localparam int STALL_W  = 32;

   localparam logic [AW-1:0] X0_ADDR = '0;

   typedef struct packed {
      logic [XLEN-1:0]   rs1_data;
      logic [XLEN-1:0]   rs2_data;
      logic [AW-1:0]     rd;
      logic              is_load;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [CTRL_W-1:0] ctrl;
   } fetch_out_t;

   // x0 reads as zero; a same-cycle writeback to the source beats the stale register file value.
   function automatic logic [XLEN-1:0] resolve_operand(
      input logic [AW-1:0]   src,
      input logic [XLEN-1:0] rf_data,
      input logic            wb_enable,
      input logic [AW-1:0]   wb_address,
      input logic [XLEN-1:0] wb_data
   );
      logic [XLEN-1:0] val;
      if (src == X0_ADDR) begin
         val = '0;
      end else if (wb_enable && (wb_address == src)) begin
         val = wb_data;
      end else begin
         val = rf_data;
      end
      return val;
   endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decode, register-file, writeback and execute-side signals of the operand fetch stage.
// The slave modport is the stage itself; the master modport is its surroundings.
interface operand_fetch_stage_if;
   import operand_fetch_stage_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [AW-1:0]     in_rs1;
   logic [AW-1:0]     in_rs2;
   logic [AW-1:0]     in_rd;
   logic              in_is_load;
   logic [XLEN-1:0]   in_pc;
   logic [XLEN-1:0]   in_imm;
   logic [CTRL_W-1:0] in_ctrl;

   logic [AW-1:0]     read_address;
   logic [AW-1:0]     read_address_two;
   logic [XLEN-1:0]   read_data;
   logic [XLEN-1:0]   read_data_two;

   logic              wb_enable;
   logic [AW-1:0]     wb_address;
   logic [XLEN-1:0]   wb_data;
   logic              flush;

   logic              out_valid;
   logic              out_ready;
   logic [XLEN-1:0]   out_rs1_data;
   logic [XLEN-1:0]   out_rs2_data;
   logic [AW-1:0]     out_rd;
   logic              out_is_load;
   logic [XLEN-1:0]   out_pc;
   logic [XLEN-1:0]   out_imm;
   logic [CTRL_W-1:0] out_ctrl;
   logic [STALL_W-1:0] stall_count;

   modport slave (
      input  in_valid, in_rs1, in_rs2, in_rd, in_is_load, in_pc, in_imm, in_ctrl,
      input  read_data, read_data_two,
      input  wb_enable, wb_address, wb_data, flush,
      input  out_ready,
      output in_ready, read_address, read_address_two,
      output out_valid, out_rs1_data, out_rs2_data, out_rd, out_is_load,
      output out_pc, out_imm, out_ctrl, stall_count
   );

   modport master (
      output in_valid, in_rs1, in_rs2, in_rd, in_is_load, in_pc, in_imm, in_ctrl,
      output read_data, read_data_two,
      output wb_enable, wb_address, wb_data, flush,
      output out_ready,
      input  in_ready, read_address, read_address_two,
      input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_is_load,
      input  out_pc, out_imm, out_ctrl, stall_count
   );

endinterface

// File: rtl/operand_fetch_stage_reg_scoreboard.sv
// Busy vector of registers awaiting a load result, with set/clear ports and two hazard queries.
// A query reports pending only if the register is not being written back this very cycle.
module reg_scoreboard
   import operand_fetch_stage_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] query_a,
   input  logic [AW-1:0] query_b,
   output logic          pending_a,
   output logic          pending_b
);

   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;

   assign pending_a = (query_a != X0_ADDR) && busy[query_a] && !(clr_en && (clr_addr == query_a));
   assign pending_b = (query_b != X0_ADDR) && busy[query_b] && !(clr_en && (clr_addr == query_b));

   // Set is applied after clear so a new load to the same register stays pending.
   always_comb begin
      busy_nxt = busy;
      if (clr_en) begin
         busy_nxt[clr_addr] = 1'b0;
      end
      if (set_en) begin
         busy_nxt[set_addr] = 1'b1;
      end
      busy_nxt[X0_ADDR] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_nxt;
      end
   end

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads both register-file ports, applies x0/bypass rules, stalls on load-use
// hazards and holds the resolved instruction in a one-entry output register toward execute.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   operand_fetch_stage_if.slave bus
);

   fetch_out_t         out_d;
   fetch_out_t         out_q;
   logic               out_valid_q;
   logic [STALL_W-1:0] stall_q;
   logic               pend_rs1;
   logic               pend_rs2;
   logic               hazard;
   logic               in_ready;
   logic               accept;

   assign bus.read_address     = bus.in_rs1;
   assign bus.read_address_two = bus.in_rs2;

   reg_scoreboard u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_en    (accept && bus.in_is_load),
      .set_addr  (bus.in_rd),
      .clr_en    (bus.wb_enable),
      .clr_addr  (bus.wb_address),
      .query_a   (bus.in_rs1),
      .query_b   (bus.in_rs2),
      .pending_a (pend_rs1),
      .pending_b (pend_rs2)
   );

   assign hazard   = bus.in_valid && (pend_rs1 || pend_rs2);
   assign in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
   assign accept   = bus.in_valid && in_ready;

   always_comb begin
      out_d          = '0;
      out_d.rs1_data = resolve_operand(bus.in_rs1, bus.read_data, bus.wb_enable,
                                       bus.wb_address, bus.wb_data);
      out_d.rs2_data = resolve_operand(bus.in_rs2, bus.read_data_two, bus.wb_enable,
                                       bus.wb_address, bus.wb_data);
      out_d.rd       = bus.in_rd;
      out_d.is_load  = bus.in_is_load;
      out_d.pc       = bus.in_pc;
      out_d.imm      = bus.in_imm;
      out_d.ctrl     = bus.in_ctrl;
   end

   // Data fields only change on accept, so a flushed or drained entry keeps its last contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_q       <= out_d;
      end else if (bus.flush || bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (hazard && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_rs1_data = out_q.rs1_data;
   assign bus.out_rs2_data = out_q.rs2_data;
   assign bus.out_rd       = out_q.rd;
   assign bus.out_is_load  = out_q.is_load;
   assign bus.out_pc       = out_q.pc;
   assign bus.out_imm      = out_q.imm;
   assign bus.out_ctrl     = out_q.ctrl;
   assign bus.stall_count  = stall_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: directed scenarios followed by randomized traffic,
// with expected execute-side bundles queued at issue and popped by an independent monitor.
module tb_operand_fetch_stage;
   import operand_fetch_stage_pkg::*;

   typedef struct packed {
      logic              in_valid;
      logic [AW-1:0]     rs1;
      logic [AW-1:0]     rs2;
      logic [AW-1:0]     rd;
      logic              is_load;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   imm;
      logic [CTRL_W-1:0] ctrl;
      logic              wb_en;
      logic [AW-1:0]     wb_addr;
      logic [XLEN-1:0]   wb_data;
      logic              flush;
      logic              out_ready;
   } stim_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   operand_fetch_stage_if bus ();
   operand_fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

   // Register file environment; entry 0 holds garbage so the x0 rule is exercised.
   logic [XLEN-1:0] rf_mem [NUM_REGS];
   assign bus.read_data     = rf_mem[bus.read_address];
   assign bus.read_data_two = rf_mem[bus.read_address_two];

   fetch_out_t          exp_q [$];
   logic [NUM_REGS-1:0] m_busy;
   logic [31:0]         m_stall;
   logic                mon_en = 1'b0;
   int                  checks = 0;
   int                  errors = 0;

   task automatic chk_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
      end
   endtask

   task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string name, input fetch_out_t act, input fetch_out_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic fetch_out_t cur_out();
      fetch_out_t o;
      o.rs1_data = bus.out_rs1_data;
      o.rs2_data = bus.out_rs2_data;
      o.rd       = bus.out_rd;
      o.is_load  = bus.out_is_load;
      o.pc       = bus.out_pc;
      o.imm      = bus.out_imm;
      o.ctrl     = bus.out_ctrl;
      return o;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.out_ready = 1'b1;
      return s;
   endfunction

   // Architectural value of a source as seen by an instruction issued with stimulus s.
   function automatic logic [XLEN-1:0] opnd(input logic [AW-1:0] r, input stim_t s);
      if (r == 0) return '0;
      if (s.wb_en && s.wb_addr == r) return s.wb_data;
      return rf_mem[r];
   endfunction

   function automatic logic waiting(input logic [AW-1:0] r, input stim_t s);
      return (r != 0) && m_busy[r] && !(s.wb_en && s.wb_addr == r);
   endfunction

   task automatic drive(input stim_t s);
      bus.in_valid   = s.in_valid;
      bus.in_rs1     = s.rs1;
      bus.in_rs2     = s.rs2;
      bus.in_rd      = s.rd;
      bus.in_is_load = s.is_load;
      bus.in_pc      = s.pc;
      bus.in_imm     = s.imm;
      bus.in_ctrl    = s.ctrl;
      bus.wb_enable  = s.wb_en;
      bus.wb_address = s.wb_addr;
      bus.wb_data    = s.wb_data;
      bus.flush      = s.flush;
      bus.out_ready  = s.out_ready;
   endtask

   // One cycle: drive at negedge, predict just before posedge, commit RF write after posedge.
   task automatic step(input stim_t s, output logic rdy);
      logic       haz;
      logic       exp_rdy;
      fetch_out_t e;
      @(negedge clk);
      drive(s);
      #4;
      haz     = s.in_valid && (waiting(s.rs1, s) || waiting(s.rs2, s));
      exp_rdy = ((exp_q.size() == 0) || s.out_ready) && !haz && !s.flush;
      rdy     = bus.in_ready;
      chk_bit("in_ready", rdy, exp_rdy);
      chk_word("stall_count", bus.stall_count, m_stall);
      if (haz && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (s.flush && exp_q.size() != 0) void'(exp_q.pop_front());
      if (s.in_valid && exp_rdy) begin
         e.rs1_data = opnd(s.rs1, s);
         e.rs2_data = opnd(s.rs2, s);
         e.rd       = s.rd;
         e.is_load  = s.is_load;
         e.pc       = s.pc;
         e.imm      = s.imm;
         e.ctrl     = s.ctrl;
         exp_q.push_back(e);
      end
      if (s.wb_en) m_busy[s.wb_addr] = 1'b0;
      if (s.in_valid && exp_rdy && s.is_load && s.rd != 0) m_busy[s.rd] = 1'b1;
      @(posedge clk);
      #1;
      if (s.wb_en && s.wb_addr != 0) rf_mem[s.wb_addr] = s.wb_data;
   endtask

   task automatic reset_mid(input stim_t s);
      @(negedge clk);
      drive(s);
      #3;
      rst = 1'b1;
      #1;
      chk_bit("rst_out_valid", bus.out_valid, 1'b0);
      chk_out("rst_out_fields", cur_out(), '0);
      chk_word("rst_stall_count", bus.stall_count, 32'd0);
      exp_q.delete();
      m_busy  = '0;
      m_stall = '0;
      drive(idle());
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: out_valid must track the model's occupancy and present the queue head.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (mon_en && !rst) begin
            chk_bit("out_valid", bus.out_valid, exp_q.size() != 0);
            if (bus.out_valid && exp_q.size() != 0) chk_out("out_bundle", cur_out(), exp_q[0]);
            if (bus.out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      stim_t s;
      logic  rdy;
      for (int i = 0; i < NUM_REGS; i++) rf_mem[i] = $urandom;
      rf_mem[0] = 32'hDEAD_0000;
      m_busy    = '0;
      m_stall   = '0;
      drive(idle());
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_bit("reset_out_valid", bus.out_valid, 1'b0);
      chk_out("reset_out_fields", cur_out(), '0);
      chk_word("reset_stall_count", bus.stall_count, 32'd0);
      chk_bit("reset_in_ready", bus.in_ready, 1'b1);
      mon_en = 1'b1;

      // RF write then read with x0 on the second port
      s = idle(); s.wb_en = 1'b1; s.wb_addr = 5'd5; s.wb_data = 32'hABCDE123;
      step(s, rdy);
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd5; s.rs2 = 5'd0; s.pc = 32'h1000;
      step(s, rdy);
      chk_bit("t1_out_valid", bus.out_valid, 1'b1);
      chk_word("t1_rs1", bus.out_rs1_data, 32'hABCDE123);
      chk_word("t1_rs2_x0", bus.out_rs2_data, 32'd0);

      // Same-cycle writeback bypass over a stale RF value
      rf_mem[10] = 32'h0BAD_0BAD;
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd10; s.rs2 = 5'd10;
      s.wb_en = 1'b1; s.wb_addr = 5'd10; s.wb_data = 32'd111;
      step(s, rdy);
      chk_word("t2_bypass", bus.out_rs1_data, 32'd111);

      // Load-use stall, then wake on the writeback cycle
      s = idle(); s.in_valid = 1'b1; s.is_load = 1'b1; s.rd = 5'd7;
      step(s, rdy);
      s = idle(); s.in_valid = 1'b1; s.rs2 = 5'd7;
      step(s, rdy);
      chk_bit("t3_stall_ready", rdy, 1'b0);
      chk_word("t3_stall_count", bus.stall_count, 32'd1);
      s.wb_en = 1'b1; s.wb_addr = 5'd7; s.wb_data = 32'd222;
      step(s, rdy);
      chk_bit("t3_wake_ready", rdy, 1'b1);
      chk_word("t3_rs2", bus.out_rs2_data, 32'd222);

      // Backpressure holds the output register
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd5; s.pc = 32'h100;
      step(s, rdy);
      s.pc = 32'h200; s.out_ready = 1'b0;
      repeat (3) begin
         step(s, rdy);
         chk_bit("t4_hold_ready", rdy, 1'b0);
         chk_word("t4_hold_pc", bus.out_pc, 32'h100);
      end
      s.out_ready = 1'b1;
      step(s, rdy);
      chk_bit("t4_release_ready", rdy, 1'b1);
      chk_word("t4_next_pc", bus.out_pc, 32'h200);

      // Load to x0 never stalls; set beats clear on the same register
      s = idle(); s.in_valid = 1'b1; s.is_load = 1'b1; s.rd = 5'd0;
      step(s, rdy);
      s = idle(); s.in_valid = 1'b1;
      step(s, rdy);
      chk_bit("t5_x0_ready", rdy, 1'b1);
      chk_word("t5_x0_opnd", bus.out_rs1_data, 32'd0);
      s = idle(); s.in_valid = 1'b1; s.is_load = 1'b1; s.rd = 5'd3;
      s.wb_en = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'h33;
      step(s, rdy);
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd3;
      step(s, rdy);
      chk_bit("t5_set_wins", rdy, 1'b0);
      s = idle(); s.wb_en = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'h44;
      step(s, rdy);

      // Flush squashes the output but keeps pending loads; then reset while stalled
      s = idle(); s.in_valid = 1'b1; s.is_load = 1'b1; s.rd = 5'd9;
      step(s, rdy);
      s = idle(); s.in_valid = 1'b1; s.flush = 1'b1; s.out_ready = 1'b0;
      step(s, rdy);
      chk_bit("t6_flush_ready", rdy, 1'b0);
      chk_bit("t6_flush_valid", bus.out_valid, 1'b0);
      s = idle(); s.in_valid = 1'b1; s.rs1 = 5'd9;
      step(s, rdy);
      chk_bit("t6_busy_kept", rdy, 1'b0);
      reset_mid(s);

      for (int n = 0; n < 3000; n++) begin
         s.in_valid  = ($urandom_range(0, 9) < 8);
         s.rs1       = 5'($urandom_range(0, 7));
         s.rs2       = 5'($urandom_range(0, 7));
         s.rd        = 5'($urandom_range(0, 7));
         s.is_load   = ($urandom_range(0, 9) < 3);
         s.pc        = $urandom;
         s.imm       = $urandom;
         s.ctrl      = 16'($urandom);
         s.wb_en     = ($urandom_range(0, 9) < 4);
         s.wb_addr   = 5'($urandom_range(0, 7));
         s.wb_data   = $urandom;
         s.out_ready = ($urandom_range(0, 9) < 7);
         s.flush     = ($urandom_range(0, 24) == 0);
         if (s.flush) s.out_ready = 1'b0;
         step(s, rdy);
      end

      s = idle();
      repeat (4) step(s, rdy);
      chk_bit("drain_out_valid", bus.out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
